// File: rtl/axi_stream_to_frame_fifo.sv
// axi_stream_to_frame_fifo: writes an AXI-Stream into one of two ping-pong frame FIFO buffers
module axi_stream_to_frame_fifo #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int USER_DEPTH      = 1,
    parameter int SIZE_WIDTH      = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [USER_DEPTH-1:0]      i_axis_user,
    output logic                       o_axis_ready,
    input  logic [AXIS_DATA_WIDTH-1:0] i_axis_data,
    input  logic                       i_axis_last,
    input  logic                       i_axis_valid,
    input  logic [1:0]                 i_frame_fifo_ready,
    output logic [1:0]                 o_frame_fifo_activate,
    input  logic [SIZE_WIDTH-1:0]      i_frame_fifo_size,
    output logic                       o_frame_fifo_stb,
    output logic                       o_frame_fifo_sof,
    output logic                       o_frame_fifo_last,
    output logic [AXIS_DATA_WIDTH-1:0] o_frame_fifo_data
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    logic [1:0]                 state_q, state_d, act_q, act_d;
    logic [SIZE_WIDTH-1:0]      count_q, count_d;
    logic                       prev_q, prev_d, stb_q, stb_d, sof_q, sof_d, last_q, last_d;
    logic [AXIS_DATA_WIDTH-1:0] data_q, data_d;
    logic                       hs, pick;
    assign o_axis_ready          = (state_q == WRITE) && (count_q < i_frame_fifo_size);
    assign hs                    = i_axis_valid && o_axis_ready;
    // both free: alternate away from the buffer used last time
    assign pick                  = (i_frame_fifo_ready == 2'b11) ? ~prev_q : i_frame_fifo_ready[1];
    assign o_frame_fifo_activate = act_q;
    assign o_frame_fifo_stb      = stb_q;
    assign o_frame_fifo_sof      = sof_q;
    assign o_frame_fifo_last     = last_q;
    assign o_frame_fifo_data     = data_q;
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        count_d = count_q;
        prev_d  = prev_q;
        stb_d   = hs;
        sof_d   = hs ? i_axis_user[0] : sof_q;
        last_d  = hs ? i_axis_last : last_q;
        data_d  = hs ? i_axis_data : data_q;
        case (state_q)
            IDLE: if (act_q == 2'b00 && |i_frame_fifo_ready) begin
                act_d   = pick ? 2'b10 : 2'b01;
                prev_d  = pick;
                count_d = '0;
                state_d = WRITE;
            end
            WRITE: if (hs) begin
                count_d = count_q + 1'b1;
                if (count_d == i_frame_fifo_size || i_axis_last) state_d = FLUSH;
            end else if (!o_axis_ready) begin
                state_d = FLUSH;
            end
            FLUSH: begin
                act_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                act_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= 2'b00;
            count_q <= '0;
            prev_q  <= 1'b1;
            stb_q   <= 1'b0;
            sof_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            count_q <= count_d;
            prev_q  <= prev_d;
            stb_q   <= stb_d;
            sof_q   <= sof_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_axi_stream_to_frame_fifo.sv
// tb_axi_stream_to_frame_fifo: directed scenarios checked cycle by cycle against an ownership model
module tb_axi_stream_to_frame_fifo;
    logic        clk = 1'b0, rst = 1'b1;
    logic [0:0]  user = '0;
    logic [31:0] data = '0;
    logic        last = 1'b0, valid = 1'b0;
    logic [1:0]  ffr = 2'b00;
    logic [23:0] size = '0;
    logic        ready_o, stb_o, sof_o, last_o;
    logic [1:0]  act_o;
    logic [31:0] data_o;
    int          pass_cnt = 0, tot_cnt = 0;
    always #5 clk = ~clk;
    axi_stream_to_frame_fifo dut (
        .clk(clk), .rst(rst), .i_axis_user(user), .o_axis_ready(ready_o),
        .i_axis_data(data), .i_axis_last(last), .i_axis_valid(valid),
        .i_frame_fifo_ready(ffr), .o_frame_fifo_activate(act_o), .i_frame_fifo_size(size),
        .o_frame_fifo_stb(stb_o), .o_frame_fifo_sof(sof_o), .o_frame_fifo_last(last_o),
        .o_frame_fifo_data(data_o)
    );
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask
    // model: which buffer is owned, words written into it, and whether it is being released
    int          m_owner = -1, m_cnt = 0, m_prev = 1;
    bit          m_closing = 0, m_started = 0;
    logic        e_stb = 0, e_sof = 0, e_last = 0;
    logic [31:0] e_data = '0;
    function automatic logic m_ready();
        return m_owner >= 0 && !m_closing && m_cnt < int'(size);
    endfunction
    function automatic logic [1:0] m_act();
        return m_owner < 0 ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
    endfunction
    always @(posedge clk) begin : model
        bit hs;
        hs = valid && m_ready();
        m_started = 1;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_prev = 1; m_closing = 0;
            e_stb = 0; e_sof = 0; e_last = 0; e_data = '0;
        end else begin
            e_stb = hs;
            if (hs) begin
                e_data = data; e_sof = user[0]; e_last = last;
            end
            if (m_owner < 0) begin
                if (ffr != 2'b00) begin
                    m_owner = (ffr == 2'b11) ? 1 - m_prev : (ffr == 2'b01 ? 0 : 1);
                    m_prev = m_owner;
                    m_cnt = 0;
                end
            end else if (m_closing) begin
                m_owner = -1; m_closing = 0;
            end else if (hs) begin
                m_cnt++;
                if (m_cnt == int'(size) || last) m_closing = 1;
            end else if (m_cnt >= int'(size)) begin
                m_closing = 1;
            end
        end
    end
    logic [1:0]  log_act[$];
    logic [31:0] log_data[$];
    logic        log_sof[$], log_last[$];
    bit          saw_ready = 0, saw_act = 0;
    always @(negedge clk) if (m_started) begin
        chk("ready", 64'(ready_o), 64'(m_ready()));
        chk("activate", 64'(act_o), 64'(m_act()));
        chk("stb", 64'(stb_o), 64'(e_stb));
        chk("data", 64'(data_o), 64'(e_data));
        chk("sof", 64'(sof_o), 64'(e_sof));
        chk("last", 64'(last_o), 64'(e_last));
        if (ready_o) saw_ready = 1;
        if (act_o == 2'b01) saw_act = 1;
        if (stb_o) begin
            log_act.push_back(act_o); log_data.push_back(data_o);
            log_sof.push_back(sof_o); log_last.push_back(last_o);
        end
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset();
        rst = 1; valid = 0; ffr = 2'b00; last = 0; user = '0;
        tick(2);
        rst = 0;
        log_act.delete(); log_data.delete(); log_sof.delete(); log_last.delete();
        saw_ready = 0; saw_act = 0;
    endtask
    task automatic send(input logic [31:0] d, input logic s, input logic l);
        int  t;
        bit  r;
        t = 0; r = 0;
        data = d; user = s; last = l; valid = 1;
        do begin
            @(negedge clk);
            r = ready_o;
            @(posedge clk);
            #1;
            t++;
        end while (!r && t < 50);
        chk("send_handshake", 64'(r), 64'd1);
        valid = 0;
    endtask
    int n_sof;
    initial begin
        // scenario 1: single buffer, 4 beats, size 4
        do_reset(); size = 4; ffr = 2'b01;
        for (int n = 0; n < 4; n++) send(32'h100 + n, n == 0, n == 3);
        tick(3);
        chk("s1_strobes", 64'(log_data.size()), 64'd4);
        chk("s1_last_on_4th", 64'(log_last[3]), 64'd1);
        chk("s1_no_early_last", 64'(log_last[2]), 64'd0);
        chk("s1_buffer", 64'(log_act[0]), 64'h1);
        // scenario 2: two 3-beat packets alternate buffers
        do_reset(); size = 16; ffr = 2'b11;
        for (int n = 0; n < 6; n++) send(32'h200 + n, n % 3 == 0, n % 3 == 2);
        tick(3);
        chk("s2_strobes", 64'(log_data.size()), 64'd6);
        chk("s2_pkt1_buf0", 64'(log_act[0]), 64'h1);
        chk("s2_pkt2_buf1", 64'(log_act[3]), 64'h2);
        // scenario 3: size 2 splits a 5-beat packet 2/2/1
        do_reset(); size = 2; ffr = 2'b11;
        for (int n = 0; n < 5; n++) send(32'h300 + n, n == 0, n == 4);
        tick(3);
        chk("s3_strobes", 64'(log_data.size()), 64'd5);
        chk("s3_split_a", {log_act[0], log_act[1]}, 64'h5);
        chk("s3_split_b", {log_act[2], log_act[3]}, 64'ha);
        chk("s3_split_c", 64'(log_act[4]), 64'h1);
        chk("s3_data4", 64'(log_data[4]), 64'h304);
        // scenario 4: valid every other cycle, SOF only on word 0
        do_reset(); size = 16; ffr = 2'b01;
        for (int n = 0; n < 6; n++) begin
            send(32'hA5A5_0000 + n, n == 0, n == 5);
            tick(1);
        end
        tick(2);
        n_sof = 0;
        foreach (log_sof[i]) n_sof += int'(log_sof[i]);
        chk("s4_strobes", 64'(log_data.size()), 64'd6);
        chk("s4_sof_first", 64'(log_sof[0]), 64'd1);
        chk("s4_sof_count", 64'(n_sof), 64'd1);
        chk("s4_data5", 64'(log_data[5]), 64'hA5A5_0005);
        // scenario 5: reset on the 2nd handshake abandons buffer 0, restart picks buffer 0
        do_reset(); size = 4; ffr = 2'b11;
        send(32'h500, 1, 0);
        data = 32'h501; valid = 1; rst = 1;
        tick(1);
        rst = 0; valid = 0;
        tick(1);
        chk("s5_suppressed", 64'(log_data.size()), 64'd1);
        send(32'h5AA, 1, 1);
        tick(3);
        chk("s5_restart_strobes", 64'(log_data.size()), 64'd2);
        chk("s5_restart_buf0", 64'(log_act[1]), 64'h1);
        chk("s5_restart_data", 64'(log_data[1]), 64'h5AA);
        // scenario 6: zero-size buffer is activated and released without writes
        do_reset(); size = 0; ffr = 2'b01;
        tick(10);
        chk("s6_strobes", 64'(log_data.size()), 64'd0);
        chk("s6_ready_never", 64'(saw_ready), 64'd0);
        chk("s6_act_pulsed", 64'(saw_act), 64'd1);
        ffr = 2'b00;
        tick(3);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
